// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default width
// and the bit-counter width helper.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } stateT;

  // Counter must index bits 0..w-1; never narrower than one bit.
  function automatic int cntWidth(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// Combinational 1-bit full subtractor (fs_cell): diff = a - b - bIn, with borrow out.
module serial_subtractor_fs_cell (
  input  logic a,
  input  logic b,
  input  logic bIn,
  output logic diff,
  output logic bOut
);

  assign diff = a ^ b ^ bIn;
  assign bOut = (~a & b) | (~a & bIn) | (b & bIn);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: oData = iData_a - iData_b - iB, one bit per clock, LSB first,
// with a start/busy/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic             iB,
  output logic [WIDTH-1:0] oData,
  output logic             oData_B,
  output logic             oBusy,
  output logic             oDone
);

  localparam int CNT_W = cntWidth(WIDTH);

  stateT            stateReg, stateNext;
  logic [WIDTH-1:0] aShReg, bShReg;
  logic [WIDTH-2:0] resShReg;
  logic [WIDTH-1:0] resNext;
  logic [WIDTH-1:0] dataReg;
  logic             dataBReg;
  logic             brwReg;
  logic [CNT_W-1:0] cntReg;
  logic             diffBit, brwNext, lastBit;

  serial_subtractor_fs_cell uCell (
    .a    (aShReg[0]),
    .b    (bShReg[0]),
    .bIn  (brwReg),
    .diff (diffBit),
    .bOut (brwNext)
  );

  // The partial result only needs WIDTH-1 bits; the final bit joins it on the last edge.
  assign resNext = {diffBit, resShReg};
  assign lastBit = (cntReg == CNT_W'(WIDTH - 1));

  always_comb begin
    stateNext = stateReg;
    unique case (stateReg)
      ST_IDLE: if (iStart) stateNext = ST_RUN;
      ST_RUN:  if (lastBit) stateNext = ST_DONE;
      ST_DONE: stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      stateReg <= ST_IDLE;
      aShReg   <= '0;
      bShReg   <= '0;
      resShReg <= '0;
      brwReg   <= 1'b0;
      cntReg   <= '0;
      dataReg  <= '0;
      dataBReg <= 1'b0;
    end else begin
      stateReg <= stateNext;
      unique case (stateReg)
        ST_IDLE: begin
          if (iStart) begin
            aShReg <= iData_a;
            bShReg <= iData_b;
            brwReg <= iB;
            cntReg <= '0;
          end
        end
        ST_RUN: begin
          aShReg   <= aShReg >> 1;
          bShReg   <= bShReg >> 1;
          brwReg   <= brwNext;
          resShReg <= resNext[WIDTH-1:1];
          cntReg   <= cntReg + CNT_W'(1);
          // Outputs move only once the whole word is known.
          if (lastBit) begin
            dataReg  <= resNext;
            dataBReg <= brwNext;
          end
        end
        default: ;
      endcase
    end
  end

  assign oData   = dataReg;
  assign oData_B = dataBReg;
  assign oBusy   = (stateReg == ST_RUN);
  assign oDone   = (stateReg == ST_DONE);

endmodule
